// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with a built-in dwell/scan sequencer.
// Define DECODER_SCAN_ACTIVE_LOW_EN to invert y for common-anode drivers.
module decoder_scan #(
  parameter int N   = 2,
  parameter int DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N-1:0]         i,
  output logic [(1<<N)-1:0]    y,
  output logic [N-1:0]         idx,
  output logic                 wrap
);

  localparam int W  = 1 << N;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [N-1:0]  TOP  = '1;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t          state_q;
  logic [W-1:0]    oh_q;
  logic [N-1:0]    idx_q;
  logic [CW-1:0]   cnt_q;
  logic            wrap_q;
  logic [N-1:0]    idx_d;

  assign idx_d = idx_q + N'(1);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q <= IDLE;
      oh_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (!mode) begin
      state_q <= DIRECT;
      oh_q    <= W'(1) << i;
      idx_q   <= i;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (state_q != SCAN) begin
      // Entry: first position gets a full dwell, never flags wrap.
      state_q <= SCAN;
      oh_q    <= W'(1) << i;
      idx_q   <= i;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q   <= '0;
      idx_q   <= idx_d;
      oh_q    <= W'(1) << idx_d;
      wrap_q  <= (idx_q == TOP);
    end else begin
      cnt_q   <= cnt_q + CW'(1);
      wrap_q  <= 1'b0;
    end
  end

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  assign y = ~oh_q;
`else
  assign y = oh_q;
`endif
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: vector table plus scan,
// wrap-period and reset-mid-scan sequences.
module tb_decoder_scan;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode;
  logic [1:0] i;
  logic [3:0] y;
  logic [1:0] idx;
  logic       wrap;

  logic       rst2, en2, mode2;
  logic [2:0] i2;
  logic [7:0] y2;
  logic [2:0] idx2;
  logic       wrap2;

  decoder_scan #(.N(2), .DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .i(i),
    .y(y), .idx(idx), .wrap(wrap)
  );

  decoder_scan #(.N(3), .DIV(1)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .i(i2),
    .y(y2), .idx(idx2), .wrap(wrap2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] p4(input logic [3:0] v);
    return AL ? ~v : v;
  endfunction

  function automatic logic [7:0] p8(input logic [7:0] v);
    return AL ? ~v : v;
  endfunction

  typedef struct {
    logic       rst, en, mode;
    logic [1:0] i;
    logic [3:0] ey;
    logic [1:0] eidx;
    logic       ew;
  } vec_t;

  vec_t v[28];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_first, wr_last, wr_cnt;
    v[0]  = '{1, 1, 1, 2, 4'b0000, 0, 0};
    v[1]  = '{1, 1, 1, 2, 4'b0000, 0, 0};
    v[2]  = '{1, 1, 1, 2, 4'b0000, 0, 0};
    v[3]  = '{0, 1, 0, 0, 4'b0001, 0, 0};
    v[4]  = '{0, 1, 0, 1, 4'b0010, 1, 0};
    v[5]  = '{0, 1, 0, 2, 4'b0100, 2, 0};
    v[6]  = '{0, 1, 0, 3, 4'b1000, 3, 0};
    v[7]  = '{0, 0, 0, 3, 4'b0000, 0, 0};
    v[8]  = '{0, 1, 1, 2, 4'b0100, 2, 0};
    for (int k = 9; k < 12; k++) v[k] = '{0, 1, 1, 0, 4'b0100, 2, 0};
    for (int k = 12; k < 16; k++) v[k] = '{0, 1, 1, 0, 4'b1000, 3, 0};
    v[16] = '{0, 1, 1, 0, 4'b0001, 0, 1};
    for (int k = 17; k < 20; k++) v[k] = '{0, 1, 1, 0, 4'b0001, 0, 0};
    v[20] = '{0, 1, 1, 0, 4'b0010, 1, 0};
    v[21] = '{0, 1, 0, 3, 4'b1000, 3, 0};
    for (int k = 22; k < 26; k++) v[k] = '{0, 1, 1, 0, 4'b0001, 0, 0};
    v[26] = '{0, 1, 1, 0, 4'b0010, 1, 0};
    v[27] = '{0, 0, 1, 0, 4'b0000, 0, 0};

    rst = 1; en = 1; mode = 1; i = 2;
    rst2 = 1; en2 = 1; mode2 = 1; i2 = 5;

    for (int k = 0; k < 28; k++) begin
      rst = v[k].rst; en = v[k].en; mode = v[k].mode; i = v[k].i;
      tick();
      chk($sformatf("v%0d_y", k), 32'(y), 32'(p4(v[k].ey)));
      chk($sformatf("v%0d_idx", k), 32'(idx), 32'(v[k].eidx));
      chk($sformatf("v%0d_wrap", k), 32'(wrap), 32'(v[k].ew));
    end

    // Wrap period: entry at 0 from idle, wraps at edges 16 and 32.
    en = 1; mode = 1; i = 0;
    wr_first = -1; wr_last = -1; wr_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (wrap) begin
        if (wr_first < 0) wr_first = c;
        wr_last = c;
        wr_cnt++;
      end
    end
    chk("wrap_first", 32'(wr_first), 32'd16);
    chk("wrap_last", 32'(wr_last), 32'd32);
    chk("wrap_count", 32'(wr_cnt), 32'd2);

    // N=3, DIV=1: advance every cycle, reset mid-scan, resume from i.
    rst2 = 0;
    tick();
    chk("s2_entry_idx", 32'(idx2), 32'd5);
    chk("s2_entry_y", 32'(y2), 32'(p8(8'b0010_0000)));
    chk("s2_entry_wrap", 32'(wrap2), 32'd0);
    tick();
    chk("s2_idx6", 32'(idx2), 32'd6);
    tick();
    chk("s2_idx7", 32'(idx2), 32'd7);
    tick();
    chk("s2_wrap_idx", 32'(idx2), 32'd0);
    chk("s2_wrap", 32'(wrap2), 32'd1);
    chk("s2_wrap_y", 32'(y2), 32'(p8(8'b0000_0001)));
    tick();
    chk("s2_idx1", 32'(idx2), 32'd1);
    chk("s2_wrap_clr", 32'(wrap2), 32'd0);
    rst2 = 1; i2 = 3;
    tick();
    chk("s2_rst_y", 32'(y2), 32'(p8(8'h00)));
    chk("s2_rst_idx", 32'(idx2), 32'd0);
    rst2 = 0;
    tick();
    chk("s2_resume_idx", 32'(idx2), 32'd3);
    chk("s2_resume_y", 32'(y2), 32'(p8(8'b0000_1000)));
    chk("s2_resume_wrap", 32'(wrap2), 32'd0);
    tick();
    chk("s2_next_idx", 32'(idx2), 32'd4);
    chk("s2_next_y", 32'(y2), 32'(p8(8'b0001_0000)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
